// File: rtl/rr_burst_request_tracker_pkg.sv
// Shared types and helpers for the round-robin burst request tracker.
// Holds requester count, field widths, channel state encoding and GNT decode helpers.
// Optional starvation monitor constants exist only when RR_TRACKER_STARVE_MON_EN is defined.
package rr_arb_pkg;

   localparam int N     = 4;
   localparam int LEN_W = 4;
   localparam int ID_W  = 2;

`ifdef RR_TRACKER_STARVE_MON_EN
   localparam int STARVE_TH = 16;
   localparam int WAIT_W    = $clog2(STARVE_TH + 1);
`endif

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } chan_state_t;

   // True when exactly one bit of the vector is set.
   function automatic logic is_onehot(input logic [N-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + int'(v[i]);
      end
      return (cnt == 1);
   endfunction

   // Binary index of a one-hot vector; zero vector maps to index 0.
   function automatic logic [ID_W-1:0] oh_to_idx(input logic [N-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            idx = idx | ID_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_burst_request_tracker_chan.sv
// Per-channel burst FSM (IDLE/ACTIVE) with remaining-beat counter.
// Latency: load to REQ one cycle; last fire to done/IDLE one cycle.
// Backpressure: counter only moves on a fired beat; loads ignored while ACTIVE.
module rr_burst_chan
   import rr_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load_valid,
   input  logic [LEN_W-1:0] i_load_len,
   input  logic             i_fire,
`ifdef RR_TRACKER_STARVE_MON_EN
   input  logic             i_gnt,
   output logic             o_starve,
`endif
   output logic             o_req,
   output logic             o_load_ready,
   output logic             o_done,
   output logic             o_err_zero_len,
   output logic [LEN_W-1:0] o_rem
);

   chan_state_t      r_state;
   logic [LEN_W-1:0] r_rem;
   logic             r_done;
   logic             r_err_zero_len;

   // Channel FSM: accept non-zero loads when idle, count down fired beats when active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_rem          <= '0;
         r_done         <= 1'b0;
         r_err_zero_len <= 1'b0;
      end else begin
         r_done         <= 1'b0;
         r_err_zero_len <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_load_valid) begin
                  if (i_load_len != '0) begin
                     r_rem   <= i_load_len;
                     r_state <= ACTIVE;
                  end else begin
                     r_err_zero_len <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               // Never decrement from zero, even if a fire arrives unexpectedly.
               if (i_fire && (r_rem != '0)) begin
                  r_rem <= r_rem - LEN_W'(1);
                  if (r_rem == LEN_W'(1)) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req          = (r_state == ACTIVE);
   assign o_load_ready   = (r_state == IDLE);
   assign o_done         = r_done;
   assign o_err_zero_len = r_err_zero_len;
   assign o_rem          = r_rem;

`ifdef RR_TRACKER_STARVE_MON_EN
   logic [WAIT_W-1:0] r_wait;
   logic              r_starve;
   logic [WAIT_W-1:0] w_wait_nxt;

   assign w_wait_nxt = (r_wait < WAIT_W'(STARVE_TH)) ? (r_wait + WAIT_W'(1)) : r_wait;

   // Wait counter saturates at the threshold; flag stays set until a grant or idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait   <= '0;
         r_starve <= 1'b0;
      end else if ((r_state == IDLE) || i_gnt) begin
         r_wait   <= '0;
         r_starve <= 1'b0;
      end else begin
         r_wait   <= w_wait_nxt;
         r_starve <= (w_wait_nxt >= WAIT_W'(STARVE_TH));
      end
   end

   assign o_starve = r_starve;
`endif

endmodule

// File: rtl/rr_burst_request_tracker.sv
// Burst request tracker feeding a 4-way round-robin arbiter; optional RR_TRACKER_STARVE_MON_EN.
// Latency: beat outputs combinational from GNT/state; REQ, done and errors registered.
// Backpressure: beat held while GNT persists and beat_ready is low; no count change.
module rr_burst_request_tracker
   import rr_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       load_valid,
   input  logic [N*LEN_W-1:0] load_len,
   output logic [N-1:0]       load_ready,
   input  logic [N-1:0]       GNT,
   output logic [N-1:0]       REQ,
   input  logic               beat_ready,
   output logic               beat_valid,
   output logic [ID_W-1:0]    beat_id,
   output logic               beat_last,
   output logic [N-1:0]       done,
   output logic [N-1:0]       err_zero_len,
`ifdef RR_TRACKER_STARVE_MON_EN
   output logic [N-1:0]       starve,
`endif
   output logic               err_gnt
);

   logic             w_onehot;
   logic [ID_W-1:0]  w_idx;
   logic             w_sel_active;
   logic             w_fire;
   logic             w_gnt_bad;
   logic [LEN_W-1:0] w_rem [N];
   logic             r_err_gnt;

   assign w_onehot     = is_onehot(GNT);
   assign w_idx        = oh_to_idx(GNT);
   assign w_sel_active = REQ[w_idx];

   assign beat_valid = w_onehot & w_sel_active;
   assign beat_id    = w_idx;
   assign beat_last  = beat_valid & (w_rem[w_idx] == LEN_W'(1));
   assign w_fire     = beat_valid & beat_ready;

   // Any non-zero GNT that is multi-hot or points at an idle channel is a protocol error.
   assign w_gnt_bad = (GNT != '0) & ~(w_onehot & w_sel_active);

   // Register the illegal-grant flag as a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_gnt <= 1'b0;
      end else begin
         r_err_gnt <= w_gnt_bad;
      end
   end

   assign err_gnt = r_err_gnt;

   for (genvar g = 0; g < N; g++) begin : g_chan
      rr_burst_chan u_chan (
         .clk            (clk),
         .rst_n          (rst_n),
         .i_load_valid   (load_valid[g]),
         .i_load_len     (load_len[g*LEN_W +: LEN_W]),
         .i_fire         (w_fire & GNT[g]),
`ifdef RR_TRACKER_STARVE_MON_EN
         .i_gnt          (GNT[g]),
         .o_starve       (starve[g]),
`endif
         .o_req          (REQ[g]),
         .o_load_ready   (load_ready[g]),
         .o_done         (done[g]),
         .o_err_zero_len (err_zero_len[g]),
         .o_rem          (w_rem[g])
      );
   end

endmodule

// File: tb/tb_rr_burst_request_tracker.sv
// Bench for rr_burst_request_tracker: directed scenarios then random traffic.
// Reference model tracks remaining beats per channel as plain integers.
// Inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
module tb_rr_burst_request_tracker;

   logic        clk;
   logic        rst_n;
   logic [3:0]  load_valid;
   logic [15:0] load_len;
   logic [3:0]  load_ready;
   logic [3:0]  GNT;
   logic [3:0]  REQ;
   logic        beat_ready;
   logic        beat_valid;
   logic [1:0]  beat_id;
   logic        beat_last;
   logic [3:0]  done;
   logic [3:0]  err_zero_len;
   logic        err_gnt;
`ifdef RR_TRACKER_STARVE_MON_EN
   logic [3:0]  starve;
`endif

   int total;
   int bad;

   int         rem_m [4];
   logic [3:0] exp_done;
   logic [3:0] exp_errz;
   logic       exp_errg;

   rr_burst_request_tracker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_len     (load_len),
      .load_ready   (load_ready),
      .GNT          (GNT),
      .REQ          (REQ),
      .beat_ready   (beat_ready),
      .beat_valid   (beat_valid),
      .beat_id      (beat_id),
      .beat_last    (beat_last),
      .done         (done),
      .err_zero_len (err_zero_len),
`ifdef RR_TRACKER_STARVE_MON_EN
      .starve       (starve),
`endif
      .err_gnt      (err_gnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] req_m();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (rem_m[i] != 0);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) rem_m[i] = 0;
      exp_done = '0;
      exp_errz = '0;
      exp_errg = 1'b0;
   endtask

   // One clock cycle: drive, check against the model, advance the model, pass the edge.
   task automatic step(input logic [3:0] g, input logic [3:0] lv, input logic [15:0] ll,
                       input logic br);
      int         cnt;
      int         idx;
      int         len;
      logic       vld;
      logic [3:0] nd;
      logic [3:0] nz;
      logic       ng;
      GNT        = g;
      load_valid = lv;
      load_len   = ll;
      beat_ready = br;
      #2;
      cnt = $countones(g);
      idx = 0;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      vld = (cnt == 1) && (rem_m[idx] > 0);
      chk("REQ", {28'd0, REQ}, {28'd0, req_m()});
      chk("load_ready", {28'd0, load_ready}, {28'd0, ~req_m()});
      chk("done", {28'd0, done}, {28'd0, exp_done});
      chk("err_zero_len", {28'd0, err_zero_len}, {28'd0, exp_errz});
      chk("err_gnt", {31'd0, err_gnt}, {31'd0, exp_errg});
      chk("beat_valid", {31'd0, beat_valid}, {31'd0, vld});
      chk("beat_last", {31'd0, beat_last}, {31'd0, (vld && rem_m[idx] == 1)});
      if (vld) chk("beat_id", {30'd0, beat_id}, idx);
      nd = '0;
      nz = '0;
      ng = (cnt > 1) || ((cnt == 1) && (rem_m[idx] == 0));
      for (int i = 0; i < 4; i++) begin
         if ((rem_m[i] == 0) && lv[i]) begin
            len = int'(ll[i*4 +: 4]);
            if (len == 0) nz[i] = 1'b1;
            else rem_m[i] = len;
         end
      end
      if (vld && br) begin
         rem_m[idx] = rem_m[idx] - 1;
         if (rem_m[idx] == 0) nd[idx] = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_done = nd;
      exp_errz = nz;
      exp_errg = ng;
   endtask

   initial begin
      logic [3:0]  rg;
      logic [3:0]  rlv;
      logic [15:0] rll;
      int          sel;
      int          c;
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      GNT        = '0;
      load_valid = '0;
      load_len   = '0;
      beat_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_REQ", {28'd0, REQ}, 32'h0);
      chk("rst_load_ready", {28'd0, load_ready}, 32'hF);
      chk("rst_beat_valid", {31'd0, beat_valid}, 32'h0);
      chk("rst_beat_id", {30'd0, beat_id}, 32'h0);
      chk("rst_beat_last", {31'd0, beat_last}, 32'h0);
      chk("rst_done", {28'd0, done}, 32'h0);
      chk("rst_err_zero_len", {28'd0, err_zero_len}, 32'h0);
      chk("rst_err_gnt", {31'd0, err_gnt}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ch0 burst of 3 with a steady grant
      step(4'b0000, 4'b0001, 16'h0003, 1'b1);
      chk("s1_REQ_after_load", {28'd0, REQ}, 32'h1);
      step(4'b0001, 4'b0000, 16'h0000, 1'b1);
      step(4'b0001, 4'b0000, 16'h0000, 1'b1);
      step(4'b0001, 4'b0000, 16'h0000, 1'b1);
      chk("s1_REQ_end", {28'd0, REQ}, 32'h0);
      chk("s1_done", {28'd0, done}, 32'h1);
      step(4'b0000, 4'b0000, 16'h0000, 1'b1);

      // ch1 burst of 2 with a stalled cycle in between
      step(4'b0000, 4'b0010, 16'h0020, 1'b1);
      step(4'b0010, 4'b0000, 16'h0000, 1'b1);
      step(4'b0010, 4'b0000, 16'h0000, 1'b0);
      chk("s2_REQ_stall", {28'd0, REQ}, 32'h2);
      step(4'b0010, 4'b0000, 16'h0000, 1'b1);
      chk("s2_done", {28'd0, done}, 32'h2);
      step(4'b0000, 4'b0000, 16'h0000, 1'b1);

      // ch1 and ch2 bursts of 4 with a time-slice switch
      step(4'b0000, 4'b0110, 16'h0440, 1'b1);
      repeat (2) step(4'b0010, 4'b0000, 16'h0000, 1'b1);
      repeat (4) step(4'b0100, 4'b0000, 16'h0000, 1'b1);
      chk("s3_done2", {28'd0, done}, 32'h4);
      chk("s3_REQ_mid", {28'd0, REQ}, 32'h2);
      repeat (2) step(4'b0010, 4'b0000, 16'h0000, 1'b1);
      chk("s3_done1", {28'd0, done}, 32'h2);
      chk("s3_REQ_end", {28'd0, REQ}, 32'h0);

      // zero-length load and illegal multi-hot grant
      step(4'b0000, 4'b1000, 16'h0000, 1'b1);
      chk("s4_err_zero_len", {28'd0, err_zero_len}, 32'h8);
      chk("s4_REQ", {28'd0, REQ}, 32'h0);
      step(4'b0000, 4'b0110, 16'h0220, 1'b1);
      step(4'b0110, 4'b0000, 16'h0000, 1'b1);
      chk("s4_err_gnt", {31'd0, err_gnt}, 32'h1);
      repeat (2) step(4'b0010, 4'b0000, 16'h0000, 1'b1);
      repeat (2) step(4'b0100, 4'b0000, 16'h0000, 1'b1);
      chk("s4_done2", {28'd0, done}, 32'h4);

      // reset in the middle of a burst
      step(4'b0000, 4'b0001, 16'h0005, 1'b1);
      repeat (2) step(4'b0001, 4'b0000, 16'h0000, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("s5_REQ_rst", {28'd0, REQ}, 32'h0);
      chk("s5_load_ready_rst", {28'd0, load_ready}, 32'hF);
      chk("s5_done_rst", {28'd0, done}, 32'h0);
      chk("s5_beat_valid_rst", {31'd0, beat_valid}, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b0000, 4'b0001, 16'h0001, 1'b1);
      step(4'b0001, 4'b0000, 16'h0000, 1'b1);
      chk("s5_done_fresh", {28'd0, done}, 32'h1);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rlv = 4'($urandom) & 4'($urandom);
         rll = 16'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            rg = 4'b0000;
         end else if (sel == 1) begin
            rg = 4'($urandom);
         end else begin
            c  = int'($urandom_range(0, 3));
            rg = 4'b0001 << c;
            for (int k = 0; k < 4; k++) begin
               if (rem_m[(c + k) % 4] != 0) begin
                  rg = 4'b0001 << ((c + k) % 4);
                  break;
               end
            end
         end
         step(rg, rlv, rll, ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
